// File: rtl/raster_pkg.sv
// Shared types, field offsets and state encoding for the raster sequencer.
package raster_pkg;

  localparam int TRI_W = 118;

  // Triangle word layout, LSB first: color, d2, d1, d0, then vertex coords v2y..v0x.
  localparam int COLOR_LSB = 0;
  localparam int D2_LSB    = 16;
  localparam int D1_LSB    = 18;
  localparam int D0_LSB    = 20;
  localparam int V2Y_LSB   = 22;
  localparam int V2X_LSB   = 38;
  localparam int V1Y_LSB   = 54;
  localparam int V1X_LSB   = 70;
  localparam int V0Y_LSB   = 86;
  localparam int V0X_LSB   = 102;

  typedef logic [TRI_W-1:0] tri_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_BOUNDS = 3'd2,
    S_EDGES  = 3'd3,
    S_LSETUP = 3'd4,
    S_RASTER = 3'd5,
    S_DRAIN  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  function automatic tri_t pack_tri(input logic [15:0] v0x, v0y, v1x, v1y, v2x, v2y,
                                    input logic [1:0] d0, d1, d2,
                                    input logic [15:0] color);
    tri_t t;
    t = '0;
    t[V0X_LSB +: 16]   = v0x;
    t[V0Y_LSB +: 16]   = v0y;
    t[V1X_LSB +: 16]   = v1x;
    t[V1Y_LSB +: 16]   = v1y;
    t[V2X_LSB +: 16]   = v2x;
    t[V2Y_LSB +: 16]   = v2y;
    t[D0_LSB +: 2]     = d0;
    t[D1_LSB +: 2]     = d1;
    t[D2_LSB +: 2]     = d2;
    t[COLOR_LSB +: 16] = color;
    return t;
  endfunction

endpackage

// File: rtl/tri_slot_buffer.sv
// Two-entry triangle holder: PEND accepts over valid/ready, load strobe moves PEND into CUR.
// Ready is simply "PEND empty", so upstream stalls while a triangle is queued behind the active one.
module tri_slot_buffer
  import raster_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             valid,
  input  logic [TRI_W-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             pend_full,
  output logic [TRI_W-1:0] cur_data
);

  logic [TRI_W-1:0] pend_data;
  logic             accept;

  assign ready  = !pend_full;
  assign accept = valid && ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      cur_data  <= '0;
    end else begin
      if (load)
        cur_data <= pend_data;
      if (accept)
        pend_data <= data;
      pend_full <= accept || (pend_full && !load);
    end
  end

endmodule

// File: rtl/raster_sequencer.sv
// Steps EdgeRasterizer through its setup stages and streams its pixels with valid/ready.
// First pixel step 4*STAGE_CYCLES+2 cycles after accept; stepping pauses while a pixel is unconsumed.
module raster_sequencer
  import raster_pkg::*;
#(
  parameter int STAGE_CYCLES = 1,
  parameter int MAX_RASTER   = 65535
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_tri_valid,
  output logic             out_tri_ready,
  input  logic [TRI_W-1:0] in_tri_data,
  output logic [TRI_W-1:0] out_tri_data,
  output logic             out_sig_start_new_triangle,
  output logic             out_sig_get_boundary_coords,
  output logic             out_sig_form_edges,
  output logic             out_sig_pixel_loop_setup,
  output logic             out_sig_rasterize_pixels,
  input  logic             in_sig_rasterize_done,
  output logic             out_pix_valid,
  input  logic             in_pix_ready,
  output logic             out_busy,
  output logic             out_tri_done,
  output logic             out_err_timeout,
  output logic [15:0]      out_tri_count
);

  localparam logic [3:0]  STAGE_LAST = 4'(STAGE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST   = 16'(MAX_RASTER - 1);

  state_t      state, state_n;
  logic [3:0]  stage_cnt;
  logic [15:0] tmo_cnt;
  logic        pix_valid;
  logic        pend_full;
  logic        load_cur;
  logic        step;
  logic        stage_last;
  logic        tmo_hit;
  logic        in_setup;

  tri_slot_buffer u_slots (
    .clock     (clock),
    .resetn    (resetn),
    .valid     (in_tri_valid),
    .data      (in_tri_data),
    .load      (load_cur),
    .ready     (out_tri_ready),
    .pend_full (pend_full),
    .cur_data  (out_tri_data)
  );

  assign in_setup   = (state == S_START) || (state == S_BOUNDS) ||
                      (state == S_EDGES) || (state == S_LSETUP);
  assign stage_last = (stage_cnt == STAGE_LAST);
  assign tmo_hit    = ((state == S_RASTER) || (state == S_DRAIN)) && (tmo_cnt == TMO_LAST);
  assign step       = (state == S_RASTER) && !in_sig_rasterize_done && (!pix_valid || in_pix_ready);

  assign out_sig_rasterize_pixels = step;
  assign out_pix_valid            = pix_valid;

  always_comb begin
    state_n  = state;
    load_cur = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_full) begin
          load_cur = 1'b1;
          state_n  = S_START;
        end
      end
      S_START:  if (stage_last) state_n = S_BOUNDS;
      S_BOUNDS: if (stage_last) state_n = S_EDGES;
      S_EDGES:  if (stage_last) state_n = S_LSETUP;
      S_LSETUP: if (stage_last) state_n = S_RASTER;
      S_RASTER: begin
        if (tmo_hit)                    state_n = S_DONE;
        else if (in_sig_rasterize_done) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (tmo_hit || !pix_valid) state_n = S_DONE;
      end
      S_DONE: begin
        if (pend_full) begin
          load_cur = 1'b1;
          state_n  = S_START;
        end else begin
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      stage_cnt <= '0;
      tmo_cnt   <= '0;
      pix_valid <= 1'b0;
    end else begin
      state     <= state_n;
      stage_cnt <= (in_setup && state_n == state) ? stage_cnt + 4'd1 : 4'd0;
      // Held at zero outside RASTER/DRAIN, so it restarts on every RASTER entry.
      tmo_cnt   <= ((state == S_RASTER) || (state == S_DRAIN)) ? tmo_cnt + 16'd1 : 16'd0;
      if (tmo_hit)
        pix_valid <= 1'b0;
      else if (step)
        pix_valid <= 1'b1;
      else if (in_pix_ready)
        pix_valid <= 1'b0;
    end
  end

  // Control outputs decode the next state so they change cleanly on the clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_sig_start_new_triangle  <= 1'b0;
      out_sig_get_boundary_coords <= 1'b0;
      out_sig_form_edges          <= 1'b0;
      out_sig_pixel_loop_setup    <= 1'b0;
      out_busy                    <= 1'b0;
      out_tri_done                <= 1'b0;
      out_err_timeout             <= 1'b0;
      out_tri_count               <= '0;
    end else begin
      out_sig_start_new_triangle  <= (state_n == S_START);
      out_sig_get_boundary_coords <= (state_n == S_BOUNDS);
      out_sig_form_edges          <= (state_n == S_EDGES);
      out_sig_pixel_loop_setup    <= (state_n == S_LSETUP);
      out_busy                    <= (state_n != S_IDLE);
      out_tri_done                <= (state_n == S_DONE);
      out_err_timeout             <= out_err_timeout || tmo_hit;
      if (state_n == S_DONE)
        out_tri_count <= out_tri_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_raster_sequencer.sv
// Directed bench: three sequencer instances (default, short timeout, 3-cycle stages) with a counting rasterizer model.
module tb_raster_sequencer;

  logic         clock = 1'b0;
  logic         resetn;
  logic [2:0]   tri_valid;
  logic [2:0]   tri_ready, s_start, s_bounds, s_edges, s_lsetup, s_step;
  logic [2:0]   rz_done, pix_valid, busy, tdone, terr;
  logic [117:0] tri_in;
  logic [117:0] cur_dat [3];
  logic [15:0]  cnt [3];
  logic         pix_ready;
  int           npix_target;
  bit           never_done;

  int tests = 0;
  int fails = 0;
  int exp_cnt [3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int SC = (g == 2) ? 3 : 1;
    localparam int MR = (g == 1) ? 50 : 65535;
    int nsteps = 0;

    raster_sequencer #(.STAGE_CYCLES(SC), .MAX_RASTER(MR)) dut (
      .clock                       (clock),
      .resetn                      (resetn),
      .in_tri_valid                (tri_valid[g]),
      .out_tri_ready               (tri_ready[g]),
      .in_tri_data                 (tri_in),
      .out_tri_data                (cur_dat[g]),
      .out_sig_start_new_triangle  (s_start[g]),
      .out_sig_get_boundary_coords (s_bounds[g]),
      .out_sig_form_edges          (s_edges[g]),
      .out_sig_pixel_loop_setup    (s_lsetup[g]),
      .out_sig_rasterize_pixels    (s_step[g]),
      .in_sig_rasterize_done       (rz_done[g]),
      .out_pix_valid               (pix_valid[g]),
      .in_pix_ready                (pix_ready),
      .out_busy                    (busy[g]),
      .out_tri_done                (tdone[g]),
      .out_err_timeout             (terr[g]),
      .out_tri_count               (cnt[g])
    );

    // Rasterizer stand-in: reports done once npix_target steps have been taken.
    always @(posedge clock) begin
      if (s_start[g])     nsteps <= 0;
      else if (s_step[g]) nsteps <= nsteps + 1;
    end
    assign rz_done[g] = !never_done && (nsteps >= npix_target);
  end

  typedef struct {
    int inst;
    int npix;
    bit nd;
    bit toggle;
    int stage;
    int lat;
    int pix;
    int gap;
    bit err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_dat(input string name, input logic [117:0] act, input logic [117:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [117:0] mk(input logic [15:0] a, b, c, d, e, f,
                                      input logic [1:0] d0, d1, d2, input logic [15:0] col);
    return {a, b, c, d, e, f, d0, d1, d2, col};
  endfunction

  task automatic run_vec(input vec_t v, input logic [117:0] t, input string tag);
    int g;
    int first [4];
    int hi [4];
    int overlap, stall, first_step, pixels, done_cyc, done_n;
    logic [3:0] sv;
    logic [117:0] dat_at_start;
    g = v.inst;
    overlap = 0; stall = 0; first_step = -1; pixels = 0; done_cyc = -1; done_n = 0;
    dat_at_start = '0;
    for (int k = 0; k < 4; k++) begin first[k] = -1; hi[k] = 0; end

    @(negedge clock);
    npix_target = v.npix;
    never_done  = v.nd;
    pix_ready   = 1'b1;
    tri_in      = t;
    chk({tag, " ready_idle"}, tri_ready[g], 1);
    tri_valid[g] = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clock);
      if (cyc == 1) tri_valid[g] = 1'b0;
      pix_ready = v.toggle ? cyc[0] : 1'b1;
      #1;
      sv = {s_lsetup[g], s_edges[g], s_bounds[g], s_start[g]};
      if ($countones(sv) > 1) overlap++;
      for (int k = 0; k < 4; k++)
        if (sv[k]) begin
          hi[k]++;
          if (first[k] < 0) first[k] = cyc;
        end
      if (s_start[g]) dat_at_start = cur_dat[g];
      if (s_step[g]) begin
        if (first_step < 0) first_step = cyc;
        if (pix_valid[g] && !pix_ready) stall++;
      end
      if (pix_valid[g] && pix_ready) pixels++;
      if (tdone[g]) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL %s done_wait: no done pulse within 400 cycles", tag);
    end
    exp_cnt[g] = exp_cnt[g] + 1;

    chk({tag, " first_step_cycle"}, first_step, v.lat);
    chk({tag, " start_first"},  first[0], 2);
    chk({tag, " bounds_first"}, first[1], 2 + v.stage);
    chk({tag, " edges_first"},  first[2], 2 + 2 * v.stage);
    chk({tag, " lsetup_first"}, first[3], 2 + 3 * v.stage);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s stage%0d_high_cycles", tag, k), hi[k], v.stage);
    chk({tag, " stage_overlap"}, overlap, 0);
    chk({tag, " step_while_stalled"}, stall, 0);
    chk({tag, " pixels"}, pixels, v.pix);
    chk({tag, " done_pulses"}, done_n, 1);
    if (v.gap >= 0) chk({tag, " step_to_done"}, done_cyc - first_step, v.gap);
    chk({tag, " err_timeout"}, terr[g], v.err);
    chk({tag, " tri_count"}, cnt[g], exp_cnt[g]);
    chk({tag, " busy_after"}, busy[g], 0);
    chk({tag, " ready_after"}, tri_ready[g], 1);
    chk_dat({tag, " tri_data"}, dat_at_start, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [117:0] tri_a;
    logic [117:0] tb2 [3];
    logic [117:0] sd [3];
    logic [117:0] prev;
    int acc, ns, nd, dviol, dn;
    int scyc [3];
    int dcyc [3];
    logic r1;

    tri_a = mk(16'd100, 16'd25, 16'd125, 16'd75, 16'd75, 16'd75, 2'd0, 2'd1, 2'd2, 16'hFF00);
    tb2[0] = mk(16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 2'd1, 2'd2, 2'd3, 16'hF00F);
    tb2[1] = mk(16'd20, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 2'd2, 2'd3, 2'd0, 16'h0FF0);
    tb2[2] = mk(16'd30, 16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 2'd3, 2'd0, 2'd1, 16'hABCD);

    //             inst npix nd  tog stage lat pix gap err
    vecs[0] = '{0, 20, 1'b0, 1'b0, 1, 6,  20, 22, 1'b0};
    vecs[1] = '{0, 20, 1'b0, 1'b1, 1, 6,  20, -1, 1'b0};
    vecs[2] = '{1, 20, 1'b1, 1'b0, 1, 6,  49, 50, 1'b1};
    vecs[3] = '{1, 20, 1'b0, 1'b0, 1, 6,  20, 22, 1'b1};
    vecs[4] = '{2, 5,  1'b0, 1'b0, 3, 14, 5,  7,  1'b0};

    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    resetn = 1'b0; tri_valid = '0; pix_ready = 1'b0; tri_in = '0;
    npix_target = 20; never_done = 1'b0;
    #3;
    chk("reset ready", tri_ready[0], 1);
    chk("reset busy", busy[0], 0);
    chk("reset sigs", {s_start[0], s_bounds[0], s_edges[0], s_lsetup[0], s_step[0]}, 0);
    chk("reset pix_valid", pix_valid[0], 0);
    chk("reset done_err", {tdone[0], terr[0]}, 0);
    chk("reset count", cnt[0], 0);
    chk_dat("reset tri_data", cur_dat[0], '0);
    #19 resetn = 1'b1;

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i], tri_a, $sformatf("vec%0d", i));

    // Back-to-back triangles with valid held high.
    npix_target = 4; never_done = 1'b0;
    acc = 0; ns = 0; nd = 0; dviol = 0; r1 = 1'b1;
    for (int i = 0; i < 3; i++) begin scyc[i] = -1; dcyc[i] = -1; sd[i] = '0; end
    prev = cur_dat[0];
    for (int cyc = 0; cyc <= 300; cyc++) begin
      @(negedge clock);
      tri_valid[0] = (acc < 3);
      tri_in = tb2[(acc < 3) ? acc : 0];
      pix_ready = 1'b1;
      #1;
      if (cyc == 1) r1 = tri_ready[0];
      if (tri_valid[0] && tri_ready[0]) acc++;
      if (cur_dat[0] != prev && !s_start[0]) dviol++;
      prev = cur_dat[0];
      if (s_start[0] && ns < 3) begin scyc[ns] = cyc; sd[ns] = cur_dat[0]; ns++; end
      if (tdone[0] && nd < 3) begin dcyc[nd] = cyc; nd++; end
      if (nd == 3 && cyc >= dcyc[2] + 3) break;
    end
    tri_valid[0] = 1'b0;
    exp_cnt[0] = exp_cnt[0] + 3;
    chk("b2b accepted", acc, 3);
    chk("b2b ready_low_after_fill", r1, 0);
    chk("b2b starts", ns, 3);
    chk("b2b dones", nd, 3);
    chk("b2b start2_after_done1", scyc[1] - dcyc[0], 1);
    chk("b2b start3_after_done2", scyc[2] - dcyc[1], 1);
    chk("b2b data_change_outside_start", dviol, 0);
    for (int i = 0; i < 3; i++) chk_dat($sformatf("b2b tri%0d_data", i), sd[i], tb2[i]);
    chk("b2b count", cnt[0], exp_cnt[0]);

    // Asynchronous reset while rasterizing with a triangle pending.
    @(negedge clock);
    npix_target = 20; never_done = 1'b0; pix_ready = 1'b1;
    tri_in = tri_a; tri_valid[0] = 1'b1;
    @(negedge clock); tri_valid[0] = 1'b0;
    @(negedge clock); tri_in = tb2[0]; tri_valid[0] = 1'b1;
    @(negedge clock); tri_valid[0] = 1'b0;
    repeat (4) @(negedge clock);
    #2;
    chk("rst_mid busy_before", busy[0], 1);
    chk("rst_mid ready_before", tri_ready[0], 0);
    chk("rst_mid stepping_before", s_step[0], 1);
    resetn = 1'b0;
    #1;
    chk("rst_mid ready", tri_ready[0], 1);
    chk("rst_mid busy", busy[0], 0);
    chk("rst_mid sigs", {s_start[0], s_bounds[0], s_edges[0], s_lsetup[0], s_step[0]}, 0);
    chk("rst_mid pix_valid", pix_valid[0], 0);
    chk("rst_mid done", tdone[0], 0);
    chk("rst_mid count", cnt[0], 0);
    chk_dat("rst_mid tri_data", cur_dat[0], '0);
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    dn = 0;
    repeat (3) begin
      @(negedge clock);
      if (tdone[0]) dn++;
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clock);
      #1;
      if (tdone[0] || busy[0]) dn++;
    end
    chk("rst_mid no_done_or_busy", dn, 0);
    run_vec(vecs[0], tri_a, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
